// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file widths and the write-back queue entry type
package mips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: producer pushes, register-file write port and decode lookup bundle
interface regfile_writeback_if;
  import mips_pkg::*;
  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0]     alu_data;
  logic                  ld_valid;
  logic [REG_ADDR_W-1:0] ld_dest;
  logic [DATA_W-1:0]     ld_data;
  logic                  wb_ready;
  logic                  regWriteC;
  logic [REG_ADDR_W-1:0] RegWrite;
  logic [DATA_W-1:0]     writeData;
  logic [REG_ADDR_W-1:0] read1;
  logic [REG_ADDR_W-1:0] read2;
  logic                  pend1;
  logic                  pend2;
  logic [DATA_W-1:0]     fwd_data1;
  logic [DATA_W-1:0]     fwd_data2;
  logic                  err_overflow;
  modport master (
    output alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data, read1, read2,
    input  wb_ready, regWriteC, RegWrite, writeData, pend1, pend2, fwd_data1, fwd_data2, err_overflow
  );
  modport slave (
    input  alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data, read1, read2,
    output wb_ready, regWriteC, RegWrite, writeData, pend1, pend2, fwd_data1, fwd_data2, err_overflow
  );
endinterface

// File: rtl/wb_queue.sv
// wb_queue: circular write-back buffer taking 0/1/2 pushes and popping the head every non-empty cycle
module wb_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      npush,
  input  wb_entry_t       e0,
  input  wb_entry_t       e1,
  output wb_entry_t       mem [DEPTH],
  output logic [PW-1:0]   rd_ptr,
  output logic [CW-1:0]   count,
  output wb_entry_t       head
);
  logic [PW-1:0] wr_ptr;
  logic          pop;
  assign pop  = count != '0;
  assign head = mem[rd_ptr];
  // e0 is the older of the two pushes and lands at wr_ptr, e1 right behind it
  always_ff @(posedge clk) begin
    if (npush != 2'd0) mem[wr_ptr] <= e0;
    if (npush == 2'd2) mem[wr_ptr + PW'(1)] <= e1;
  end
  // pointers wrap modulo DEPTH; count tracks accepted pushes minus the head pop
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(npush);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(npush) - CW'(pop);
    end
  end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: ordered ALU/load write-back queue with pending-destination lookup (optional WB_BYPASS_EN forwards data)
module regfile_writeback
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  regfile_writeback_if.slave wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  wb_entry_t       mem [DEPTH];
  wb_entry_t       head, ld_e, alu_e, e0;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count, free;
  logic [1:0]      npush;
  logic            va, vb, acc_ld, acc_alu, drop;
  logic            p1, p2;
  logic [DATA_W-1:0] d1, d2;
  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk(clk), .reset(reset), .npush(npush), .e0(e0), .e1(alu_e),
    .mem(mem), .rd_ptr(rd_ptr), .count(count), .head(head)
  );
  // writes to r0 are dropped silently; the load is older and wins the last free slot
  always_comb begin
    ld_e    = '{dest: wb.ld_dest, data: wb.ld_data};
    alu_e   = '{dest: wb.alu_dest, data: wb.alu_data};
    va      = wb.ld_valid && wb.ld_dest != REG_ZERO;
    vb      = wb.alu_valid && wb.alu_dest != REG_ZERO;
    free    = CW'(DEPTH) - count;
    acc_ld  = va && free != '0;
    acc_alu = vb && (va ? free >= CW'(2) : free != '0);
    npush   = {1'b0, acc_ld} + {1'b0, acc_alu};
    drop    = (va && !acc_ld) || (vb && !acc_alu);
    e0      = acc_ld ? ld_e : alu_e;
  end
  // sticky until reset
  always_ff @(posedge clk) begin
    if (reset) wb.err_overflow <= 1'b0;
    else if (drop) wb.err_overflow <= 1'b1;
  end
  // scan oldest to youngest so the youngest match is the one left standing
  always_comb begin
    p1 = 1'b0;
    p2 = 1'b0;
    d1 = '0;
    d2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count && wb.read1 != REG_ZERO && mem[rd_ptr + PW'(k)].dest == wb.read1) begin
        p1 = 1'b1;
`ifdef WB_BYPASS_EN
        d1 = mem[rd_ptr + PW'(k)].data;
`endif
      end
      if (CW'(k) < count && wb.read2 != REG_ZERO && mem[rd_ptr + PW'(k)].dest == wb.read2) begin
        p2 = 1'b1;
`ifdef WB_BYPASS_EN
        d2 = mem[rd_ptr + PW'(k)].data;
`endif
      end
    end
  end
  assign wb.pend1     = p1;
  assign wb.pend2     = p2;
  assign wb.fwd_data1 = d1;
  assign wb.fwd_data2 = d2;
  assign wb.wb_ready  = count <= CW'(DEPTH - 2);
  assign wb.regWriteC = count != '0;
  assign wb.RegWrite  = count != '0 ? head.dest : REG_ZERO;
  assign wb.writeData = count != '0 ? head.data : '0;
endmodule
